// File: rtl/if_fetch_queue_pkg.sv
// Shared types and widths for the fetch-side queue.
//   PC_WIDTH / INSTR_WIDTH / XLEN : datapath widths used across the core.
//   ifq_state_t                   : fetch state (RUN fetching, HALT after a faulting fetch).
//   ifq_entry_t                   : one captured fetch packet as stored in the queue.
package if_fetch_queue_pkg;

    localparam int unsigned PC_WIDTH    = 64;
    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned XLEN        = 64;

    localparam int unsigned IFQ_ENTRY_WIDTH = PC_WIDTH + INSTR_WIDTH + 3;

    typedef enum logic {
        IFQ_RUN  = 1'b0,
        IFQ_HALT = 1'b1
    } ifq_state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
        logic                   prdt_taken;
        logic                   pc_misalign;
        logic                   bus_err;
    } ifq_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Generic synchronous FIFO.
//   clk_i / rst_i : clock, synchronous active-high reset (zeroes storage too).
//   clr_i         : empties the FIFO (pointers and count) without touching storage.
//   wr_en_i / wr_data_i : push request and data; accepted when not full, or when
//                         full and a pop happens in the same cycle.
//   rd_en_i / rd_data_o : pop request; rd_data_o is always the head entry.
//   empty_o / full_o    : occupancy flags.
module if_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_rd;
    logic             do_wr;

    assign empty_o   = (count == '0);
    assign full_o    = (count == (AW+1)'(DEPTH));
    assign rd_data_o = mem[rd_ptr];

    assign do_rd = rd_en_i & ~empty_o;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_wr = wr_en_i & (~full_o | do_rd);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch-side sequential stage around the combinational IF unit.
//   IF_pc_o              : registered fetch PC driving the IF unit.
//   ifu_*_i              : IF unit results for IF_pc_o, valid in the same cycle.
//   if_flush_i/flush_pc_i: redirect; empties the queue and reloads the PC.
//   id_valid_o/id_ready_i: handshake towards ID; id_* carry the head packet.
//   ifq_halted_o         : fetch stopped after a faulting fetch, until a flush.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned         DEPTH    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic [PC_WIDTH-1:0]    IF_pc_o,
    input  logic [PC_WIDTH-1:0]    ifu_pc_next_i,
    input  logic [INSTR_WIDTH-1:0] ifu_instr_i,
    input  logic                   ifu_prdt_taken_i,
    input  logic                   ifu_pc_misalign_i,
    input  logic                   ifu_bus_err_i,
    input  logic                   if_flush_i,
    input  logic [PC_WIDTH-1:0]    flush_pc_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [PC_WIDTH-1:0]    id_pc_o,
    output logic [INSTR_WIDTH-1:0] id_instr_o,
    output logic                   id_prdt_taken_o,
    output logic                   id_pc_misalign_o,
    output logic                   id_bus_err_o,
    output logic                   ifq_halted_o
);

    ifq_state_t                 state_q;
    ifq_state_t                 state_d;
    logic [PC_WIDTH-1:0]        pc_q;
    ifq_entry_t                 wr_entry;
    ifq_entry_t                 rd_entry;
    logic [IFQ_ENTRY_WIDTH-1:0] rd_data;
    logic                       empty;
    logic                       full;
    logic                       deq;
    logic                       space;
    logic                       enq;
    logic                       fault;

    assign deq   = id_valid_o & id_ready_i;
    assign space = ~full | deq;
    assign enq   = (state_q == IFQ_RUN) & space & ~if_flush_i;
    assign fault = ifu_pc_misalign_i | ifu_bus_err_i;

    assign wr_entry = '{
        pc:          pc_q,
        instr:       ifu_instr_i,
        prdt_taken:  ifu_prdt_taken_i,
        pc_misalign: ifu_pc_misalign_i,
        bus_err:     ifu_bus_err_i
    };

    if_fifo #(
        .WIDTH(IFQ_ENTRY_WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (if_flush_i),
        .wr_en_i  (enq),
        .wr_data_i(wr_entry),
        .rd_en_i  (deq),
        .rd_data_o(rd_data),
        .empty_o  (empty),
        .full_o   (full)
    );

    assign rd_entry = ifq_entry_t'(rd_data);

    assign IF_pc_o          = pc_q;
    assign id_valid_o       = ~empty;
    assign id_pc_o          = rd_entry.pc;
    assign id_instr_o       = rd_entry.instr;
    assign id_prdt_taken_o  = rd_entry.prdt_taken;
    assign id_pc_misalign_o = rd_entry.pc_misalign;
    assign id_bus_err_o     = rd_entry.bus_err;
    assign ifq_halted_o     = (state_q == IFQ_HALT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IFQ_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (if_flush_i) begin
                pc_q <= flush_pc_i;
            end else if (enq) begin
                pc_q <= ifu_pc_next_i;
            end
        end
    end

    // The faulting packet is still enqueued; only later fetches are blocked.
    always_comb begin
        state_d = state_q;
        if (if_flush_i) begin
            state_d = IFQ_RUN;
        end else if (enq && fault) begin
            state_d = IFQ_HALT;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    localparam int unsigned DEPTH = 2;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [63:0] NO_PC  = '1;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [63:0] IF_pc_o;
    logic [63:0] ifu_pc_next_i;
    logic [31:0] ifu_instr_i;
    logic        ifu_prdt_taken_i;
    logic        ifu_pc_misalign_i;
    logic        ifu_bus_err_i;
    logic        if_flush_i;
    logic [63:0] flush_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [63:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        id_prdt_taken_o;
    logic        id_pc_misalign_o;
    logic        id_bus_err_o;
    logic        ifq_halted_o;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .RESET_PC(RST_PC),
        .DEPTH(DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .IF_pc_o          (IF_pc_o),
        .ifu_pc_next_i    (ifu_pc_next_i),
        .ifu_instr_i      (ifu_instr_i),
        .ifu_prdt_taken_i (ifu_prdt_taken_i),
        .ifu_pc_misalign_i(ifu_pc_misalign_i),
        .ifu_bus_err_i    (ifu_bus_err_i),
        .if_flush_i       (if_flush_i),
        .flush_pc_i       (flush_pc_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_pc_o          (id_pc_o),
        .id_instr_o       (id_instr_o),
        .id_prdt_taken_o  (id_prdt_taken_o),
        .id_pc_misalign_o (id_pc_misalign_o),
        .id_bus_err_o     (id_bus_err_o),
        .ifq_halted_o     (ifq_halted_o)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a packet queue plus fetch PC and halt flag.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic        mis;
        logic        berr;
    } pkt_t;

    pkt_t        m_q[$];
    logic [63:0] m_pc = RST_PC;
    bit          m_halt = 0;
    bit          model_on = 0;

    always @(posedge clk) begin
        bit   d, e;
        pkt_t p;
        if (rst_i) begin
            m_q.delete();
            m_pc     = RST_PC;
            m_halt   = 0;
            model_on = 1;
        end else begin
            d = (m_q.size() > 0) && id_ready_i;
            e = !m_halt && ((m_q.size() < DEPTH) || d) && !if_flush_i;
            if (if_flush_i) begin
                m_q.delete();
                m_pc   = flush_pc_i;
                m_halt = 0;
            end else begin
                if (d) void'(m_q.pop_front());
                if (e) begin
                    p.pc    = m_pc;
                    p.instr = ifu_instr_i;
                    p.taken = ifu_prdt_taken_i;
                    p.mis   = ifu_pc_misalign_i;
                    p.berr  = ifu_bus_err_i;
                    m_q.push_back(p);
                    m_pc = ifu_pc_next_i;
                    if (ifu_pc_misalign_i || ifu_bus_err_i) m_halt = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model (all outputs are registered).
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_if_pc", IF_pc_o, m_pc);
            chk("m_valid", 64'(id_valid_o), 64'(m_q.size() != 0));
            chk("m_halted", 64'(ifq_halted_o), 64'(m_halt));
            if (m_q.size() != 0) begin
                chk("m_id_pc", id_pc_o, m_q[0].pc);
                chk("m_id_instr", 64'(id_instr_o), 64'(m_q[0].instr));
                chk("m_id_taken", 64'(id_prdt_taken_o), 64'(m_q[0].taken));
                chk("m_id_mis", 64'(id_pc_misalign_o), 64'(m_q[0].mis));
                chk("m_id_berr", 64'(id_bus_err_o), 64'(m_q[0].berr));
            end
        end
    end

    logic [63:0] err_pc = NO_PC;

    // Emulates the combinational IF unit for the directed phase.
    task automatic drive_ifu();
        ifu_pc_next_i     = m_pc + 64'd4;
        ifu_instr_i       = m_pc[31:0] ^ 32'h0000_0013;
        ifu_prdt_taken_i  = m_pc[3];
        ifu_pc_misalign_i = 1'b0;
        ifu_bus_err_i     = (m_pc == err_pc);
    endtask

    task automatic step();
        @(negedge clk);
        drive_ifu();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i      = 1'b1;
        if_flush_i = 1'b1;
        flush_pc_i = 64'h8000_1000;
        id_ready_i = 1'b0;
        drive_ifu();

        // Reset together with flush: reset wins, entries zeroed.
        step();
        rst_i = 1'b0;
        if_flush_i = 1'b0;
        chk("rst_if_pc", IF_pc_o, 64'h8000_0000);
        chk("rst_valid", 64'(id_valid_o), 64'd0);
        chk("rst_halted", 64'(ifq_halted_o), 64'd0);
        chk("rst_id_pc_zero", id_pc_o, 64'd0);

        // Streaming with ready held high.
        id_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("stream_if_pc", IF_pc_o, 64'h8000_0000 + 64'(4 * k));
            chk("stream_id_pc", id_pc_o, 64'h8000_0000 + 64'(4 * (k - 1)));
            chk("stream_valid", 64'(id_valid_o), 64'd1);
        end

        // Back-pressure from empty, then release.
        do_reset();
        id_ready_i = 1'b0;
        repeat (5) step();
        chk("stall_if_pc", IF_pc_o, 64'h8000_0008);
        chk("stall_id_pc", id_pc_o, 64'h8000_0000);
        id_ready_i = 1'b1;
        step();
        chk("full_deq_enq_id_pc", id_pc_o, 64'h8000_0004);
        chk("full_deq_enq_if_pc", IF_pc_o, 64'h8000_000C);
        chk("full_deq_enq_valid", 64'(id_valid_o), 64'd1);
        step();
        chk("release_id_pc", id_pc_o, 64'h8000_0008);
        chk("release_if_pc", IF_pc_o, 64'h8000_0010);

        // Flush with two entries queued.
        do_reset();
        id_ready_i = 1'b0;
        repeat (2) step();
        if_flush_i = 1'b1;
        flush_pc_i = 64'h8000_1000;
        step();
        if_flush_i = 1'b0;
        chk("flush_valid", 64'(id_valid_o), 64'd0);
        chk("flush_if_pc", IF_pc_o, 64'h8000_1000);
        step();
        chk("flush_id_pc", id_pc_o, 64'h8000_1000);
        chk("flush_id_valid", 64'(id_valid_o), 64'd1);

        // Bus error halts fetch until a flush.
        do_reset();
        id_ready_i = 1'b1;
        err_pc = 64'h8000_0010;
        drive_ifu();
        repeat (5) step();
        chk("berr_halted", 64'(ifq_halted_o), 64'd1);
        chk("berr_id_pc", id_pc_o, 64'h8000_0010);
        chk("berr_id_flag", 64'(id_bus_err_o), 64'd1);
        chk("berr_if_pc", IF_pc_o, 64'h8000_0014);
        err_pc = NO_PC;
        drive_ifu();
        for (int k = 0; k < 10; k++) begin
            step();
            chk("halt_valid", 64'(id_valid_o), 64'd0);
            chk("halt_if_pc", IF_pc_o, 64'h8000_0014);
        end
        if_flush_i = 1'b1;
        flush_pc_i = 64'h8000_2000;
        step();
        if_flush_i = 1'b0;
        chk("resume_if_pc", IF_pc_o, 64'h8000_2000);
        chk("resume_halted", 64'(ifq_halted_o), 64'd0);
        step();
        chk("resume_id_pc", id_pc_o, 64'h8000_2000);
        chk("resume_valid", 64'(id_valid_o), 64'd1);

        // Misalign halt, then reset and flush in the same cycle.
        ifu_pc_misalign_i = 1'b1;
        step();
        chk("mis_halted", 64'(ifq_halted_o), 64'd1);
        rst_i      = 1'b1;
        if_flush_i = 1'b1;
        flush_pc_i = 64'h8000_3000;
        step();
        rst_i      = 1'b0;
        if_flush_i = 1'b0;
        chk("rstflush_if_pc", IF_pc_o, 64'h8000_0000);
        chk("rstflush_valid", 64'(id_valid_o), 64'd0);
        chk("rstflush_halted", 64'(ifq_halted_o), 64'd0);

        // Randomized traffic, checked every cycle by the model process.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst_i             = ($urandom_range(0, 199) == 0);
            if_flush_i        = ($urandom_range(0, 19) == 0);
            flush_pc_i        = {32'h0, $urandom() & 32'hFFFF_FFFC};
            id_ready_i        = ($urandom_range(0, 2) != 0);
            ifu_instr_i       = $urandom();
            ifu_prdt_taken_i  = 1'($urandom_range(0, 1));
            ifu_pc_misalign_i = ($urandom_range(0, 39) == 0);
            ifu_bus_err_i     = ($urandom_range(0, 39) == 0);
            ifu_pc_next_i     = ($urandom_range(0, 7) == 0) ? {$urandom(), $urandom()}
                                                             : m_pc + 64'd4;
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
